// File: rtl/cpu6_timer_pkg.sv
// Shared register map, field bounds and bus-width default for the cpu6 machine timer.
`default_nettype none

`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

package cpu6_timer_pkg;

  localparam logic [4:0] CPU6_TIMER_MTIME_LO    = 5'h00;
  localparam logic [4:0] CPU6_TIMER_MTIME_HI    = 5'h04;
  localparam logic [4:0] CPU6_TIMER_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] CPU6_TIMER_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] CPU6_TIMER_CTRL        = 5'h10;
  localparam logic [4:0] CPU6_TIMER_SNAP        = 5'h14;

  localparam int CPU6_TIMER_CTRL_EN        = 0;
  localparam int CPU6_TIMER_PRESCALE_HIGH  = 15;
  localparam int CPU6_TIMER_PRESCALE_LOW   = 8;

  typedef enum logic [2:0] {
    REG_MTIME_LO    = CPU6_TIMER_MTIME_LO[4:2],
    REG_MTIME_HI    = CPU6_TIMER_MTIME_HI[4:2],
    REG_MTIMECMP_LO = CPU6_TIMER_MTIMECMP_LO[4:2],
    REG_MTIMECMP_HI = CPU6_TIMER_MTIMECMP_HI[4:2],
    REG_CTRL        = CPU6_TIMER_CTRL[4:2],
    REG_SNAP        = CPU6_TIMER_SNAP[4:2],
    REG_RSVD0       = 3'd6,
    REG_RSVD1       = 3'd7
  } reg_e;

  function automatic reg_e word_sel(input logic [4:0] byte_off);
    return reg_e'(byte_off[4:2]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu6_timer_cnt64.sv
// 64-bit mtime counter: per-half software load, tick increment, load overrides increment.
`default_nettype none

module cpu6_timer_cnt64
  import cpu6_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_i,
  input  logic        ld_lo_i,
  input  logic        ld_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtime_d_o
);

  logic [63:0] mtime_q;
  logic [63:0] mtime_d;

  // Any load suppresses the increment, so the untouched half keeps its pre-increment value.
  always_comb begin
    mtime_d = mtime_q;
    if (ld_lo_i || ld_hi_i) begin
      if (ld_lo_i) mtime_d[31:0]  = wdata_i;
      if (ld_hi_i) mtime_d[63:32] = wdata_i;
    end else if (tick_i) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mtime_q <= 64'd0;
    else        mtime_q <= mtime_d;
  end

  assign mtime_o   = mtime_q;
  assign mtime_d_o = mtime_d;

endmodule

`default_nettype wire

// File: rtl/cpu6_timer.sv
// cpu6 machine timer: memory-mapped mtime/mtimecmp with registered level interrupt.
// Optional prescaler enabled by defining CPU6_TIMER_PRESCALER_EN.
`default_nettype none

module cpu6_timer
  import cpu6_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          XLEN      = `CPU6_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sel,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            tmr_irq_r
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("cpu6_timer supports only a 32-bit data bus");
  end
  if (BASE_ADDR[4:0] != 5'd0) begin : g_base_chk
    $error("cpu6_timer window must be 32-byte aligned");
  end

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

  reg_e  reg_sel;
  logic  wr_en, rd_en, wr_ctrl;
  assign reg_sel = word_sel(addr);
  assign wr_en   = sel & we;
  assign rd_en   = sel & ~we;
  assign wr_ctrl = wr_en && (reg_sel == REG_CTRL);

  logic        en_q, en_d;
  logic        tick;
  logic [7:0]  prescale_rd;
  logic [63:0] mtime, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] snap_q;

  assign en_d = wr_ctrl ? wdata[CPU6_TIMER_CTRL_EN] : en_q;

`ifdef CPU6_TIMER_PRESCALER_EN
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] ps_cnt_q, ps_cnt_d;

  assign prescale_d  = wr_ctrl ? wdata[CPU6_TIMER_PRESCALE_HIGH:CPU6_TIMER_PRESCALE_LOW] : prescale_q;
  assign tick        = en_q && (ps_cnt_q == prescale_q);
  assign prescale_rd = prescale_q;

  always_comb begin
    ps_cnt_d = ps_cnt_q + 8'd1;
    if (wr_ctrl || !en_q || tick) ps_cnt_d = 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_q <= 8'd0;
      ps_cnt_q   <= 8'd0;
    end else begin
      prescale_q <= prescale_d;
      ps_cnt_q   <= ps_cnt_d;
    end
  end
`else
  assign tick        = en_q;
  assign prescale_rd = 8'd0;
`endif

  cpu6_timer_cnt64 u_cnt (
    .clk       (clk),
    .rst_n     (reset),
    .tick_i    (tick),
    .ld_lo_i   (wr_en && (reg_sel == REG_MTIME_LO)),
    .ld_hi_i   (wr_en && (reg_sel == REG_MTIME_HI)),
    .wdata_i   (wdata),
    .mtime_o   (mtime),
    .mtime_d_o (mtime_d)
  );

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_en && (reg_sel == REG_MTIMECMP_LO)) mtimecmp_d[31:0]  = wdata;
    if (wr_en && (reg_sel == REG_MTIMECMP_HI)) mtimecmp_d[63:32] = wdata;
  end

  // Interrupt compares next-state values so it tracks the register contents seen after the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      snap_q     <= 32'd0;
      tmr_irq_r  <= 1'b0;
    end else begin
      en_q       <= en_d;
      mtimecmp_q <= mtimecmp_d;
      if (rd_en && (reg_sel == REG_MTIME_LO)) snap_q <= mtime[63:32];
      tmr_irq_r  <= en_d & (mtime_d >= mtimecmp_d);
    end
  end

  always_comb begin
    rdata = '0;
    if (reset && sel) begin
      case (reg_sel)
        REG_MTIME_LO:    rdata = mtime[31:0];
        REG_MTIME_HI:    rdata = mtime[63:32];
        REG_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
        REG_CTRL:        rdata = {16'd0, prescale_rd, 7'd0, en_q};
        REG_SNAP:        rdata = snap_q;
        REG_RSVD0:       rdata = '0;
        REG_RSVD1:       rdata = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu6_timer.sv
// Scoreboard bench for cpu6_timer: reads push expected data/irq, a monitor pops and compares.
`timescale 1ns/1ps
`default_nettype none

module tb_cpu6_timer;

`ifdef CPU6_TIMER_PRESCALER_EN
  localparam bit PS = 1'b1;
`else
  localparam bit PS = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic [4:0]  addr  = 5'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  event ev_sample;

  always #5 clk = ~clk;

  cpu6_timer dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tmr_irq_r (irq)
  );

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or ev_sample);
      if (sel && !we) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: rdata=%h irq=%b with no expected entry", rdata, irq);
        end else begin
          e = sb.pop_front();
          if (rdata !== e.data || irq !== e.irq) begin
            errors++;
            $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                     e.name, rdata, irq, e.data, e.irq);
          end
        end
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] d, input logic i, input string n);
    sb.push_back('{n, d, i});
    sel = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #22 reset = 1'b1;
    @(posedge clk); #1;

    rd(5'h00, 32'h0,         1'b0, "rst_mtime_lo");
    rd(5'h04, 32'h0,         1'b0, "rst_mtime_hi");
    rd(5'h08, 32'hFFFF_FFFF, 1'b0, "rst_cmp_lo");
    rd(5'h0C, 32'hFFFF_FFFF, 1'b0, "rst_cmp_hi");
    rd(5'h10, 32'h0,         1'b0, "rst_ctrl");
    rd(5'h14, 32'h0,         1'b0, "rst_snap");
    rd(5'h18, 32'h0,         1'b0, "rst_rsvd18");
    rd(5'h1C, 32'h0,         1'b0, "rst_rsvd1c");

    // Compare at 10: irq is high in the same cycle mtime reads 10.
    wr(5'h0C, 32'd0);
    wr(5'h08, 32'd10);
    wr(5'h10, 32'h1);
    for (int j = 0; j <= 10; j++) rd(5'h00, j, (j >= 10), "count_irq");
    wr(5'h08, 32'd100);
    rd(5'h00, 32'd12, 1'b0, "irq_drop");

    // Carry into the high half and coherent snapshot.
    wr(5'h10, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h10, 32'h1);
    rd(5'h00, 32'hFFFF_FFFE, 1'b1, "carry_lo_fe");
    rd(5'h00, 32'hFFFF_FFFF, 1'b1, "carry_lo_ff");
    rd(5'h04, 32'h1,         1'b1, "carry_hi");
    rd(5'h14, 32'h0,         1'b1, "snap_hi");
    rd(5'h00, 32'h2,         1'b1, "carry_lo_after");

    // Software write collides with a tick.
    wr(5'h00, 32'd5);
    rd(5'h00, 32'd5, 1'b1, "collide_lo");
    rd(5'h00, 32'd6, 1'b1, "collide_next");
    rd(5'h04, 32'd1, 1'b1, "collide_hi");
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'd7);
    rd(5'h00, 32'hFFFF_FFFF, 1'b1, "hi_wr_lo_kept");
    rd(5'h04, 32'd8,         1'b1, "hi_wr_resume");

    // Prescale field: divide-by-4 when built with the prescaler, else every cycle.
    wr(5'h10, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h00, 32'h0);
    wr(5'h10, 32'h0000_0301);
    for (int k = 0; k <= 8; k++) rd(5'h00, PS ? (k / 4) : k, 1'b0, "prescale_count");
    rd(5'h10, PS ? 32'h0000_0301 : 32'h0000_0001, 1'b0, "prescale_ctrl");

    // Asynchronous reset while irq is high.
    wr(5'h08, 32'd2);
    idle(8);
    rd(5'h04, 32'h0, 1'b1, "pre_reset_irq");
    #1 reset = 1'b0;
    #1;
    sb.push_back('{"async_reset", 32'h0, 1'b0});
    sel = 1'b1; we = 1'b0; addr = 5'h00;
    ->ev_sample;
    #1 sel = 1'b0;
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    rd(5'h00, 32'h0,         1'b0, "post_rst_lo");
    rd(5'h04, 32'h0,         1'b0, "post_rst_hi");
    rd(5'h10, 32'h0,         1'b0, "post_rst_ctrl");
    rd(5'h08, 32'hFFFF_FFFF, 1'b0, "post_rst_cmp_lo");
    rd(5'h0C, 32'hFFFF_FFFF, 1'b0, "post_rst_cmp_hi");

    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu6_timer.md
Name: cpu6_timer

Overview:
- Machine timer peripheral that feeds the core's tmr_irq_r input.
- Holds a 64-bit free-running mtime counter and a 64-bit mtimecmp register, both memory-mapped on the core's data bus.
- Raises a registered, level-sensitive interrupt while mtime >= mtimecmp and the timer is enabled.
- The core gates the interrupt with mtie; this block does no masking.

Parameters:
- BASE_ADDR, 32'h0200_0000: byte base address of the 32-byte register window.
- XLEN, 32: data bus width; fixed to `CPU6_XLEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronous to clk.
- sel  input  1  bus access targets this block; decoded upstream from dataaddr.
- we  input  1  write strobe (core memwriteM); meaningful only when sel=1.
- addr  input  5  byte offset within the window; addr[1:0] ignored.
- wdata  input  32  write data (core writedata).
- rdata  output  32  read data; combinational from registers, valid in the same cycle as sel.
- tmr_irq_r  output  1  registered timer interrupt request to the core.

Behaviour:
- Register map (word offsets):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN, bit1 reserved, bits[15:8] PRESCALE
  - 0x14 MTIME_HI_SNAP (read-only)
  - 0x18, 0x1C read as 0; writes ignored.
- Reset values:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - CTRL = 0 (timer stopped)
  - snapshot = 0; prescale counter = 0
  - tmr_irq_r = 0; rdata = 0 while reset is low.
- Count:
  - When EN=1 and a tick occurs, mtime <= mtime + 1, modulo 2^64.
  - Wrap from all-ones to 0 is silent; there is no overflow flag.
- Software write to MTIME_LO or MTIME_HI:
  - Replaces only that half.
  - Overrides the increment in that cycle; the other half keeps its pre-increment value.
  - Counting resumes on the next tick.
- MTIMECMP_LO and MTIMECMP_HI writes replace that half only; no increment interaction.
- 64-bit read atomicity:
  - A read of MTIME_LO (sel=1, we=0, offset 0x00) captures mtime[63:32] into the snapshot register on the same clock edge.
  - Software reads LO, then MTIME_HI_SNAP, to get a coherent value.
- Interrupt:
  - tmr_irq_r <= EN & (mtime_next >= mtimecmp_next), one register stage.
  - Deasserts the cycle after mtimecmp is written above mtime, or after EN is cleared.
  - No sticky state; a level is held as long as the condition holds.
- Priority within one edge: reset > software write > increment.
- Read of a half being written in the same cycle returns the old value; rdata reflects register state before the edge.
- Writes to CTRL take effect next cycle. Clearing EN freezes mtime and zeroes the prescale counter.
- Reset asserted mid-count clears everything asynchronously; no partial state survives.

Optional Feature:
- Macro: CPU6_TIMER_PRESCALER_EN.
- Defined:
  - An 8-bit prescale counter counts 0..PRESCALE.
  - A tick is issued when the counter equals PRESCALE, then the counter returns to 0.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=3 gives a tick every 4 cycles.
  - Writing CTRL resets the prescale counter to 0.
- Not defined:
  - CTRL[15:8] reads as 0 and writes to it are ignored.
  - A tick occurs every cycle while EN=1; no prescale counter flops exist.

Decomposition:
- Add to defines.v:
  - CPU6_TIMER_MTIME_LO/HI, CPU6_TIMER_MTIMECMP_LO/HI, CPU6_TIMER_CTRL, CPU6_TIMER_SNAP offset constants
  - CPU6_TIMER_CTRL_EN bit index
  - CPU6_TIMER_PRESCALE_HIGH/LOW field bounds
- All flops use the existing cpu6_dfflr-style primitives with async active-low reset.
- One natural sub-module: cpu6_timer_cnt64. It holds the 64-bit counter with per-half load, tick increment and the override rule.

Test Plan:
- Reset, then read all offsets:
  - MTIME = 0, MTIMECMP_LO/HI = 32'hFFFF_FFFF, CTRL = 0, tmr_irq_r = 0.
- Write MTIMECMP = 10, then CTRL = 1:
  - mtime counts 0, 1, 2, ...
  - tmr_irq_r rises on the edge where mtime becomes 10; it is high when mtime reads 10.
  - Writing MTIMECMP_LO = 100 drops irq one cycle later.
- Carry and snapshot:
  - Write MTIME_HI = 0, MTIME_LO = 32'hFFFF_FFFE, enable.
  - After 2 ticks, MTIME_HI = 1 and MTIME_LO = 0.
  - A LO read at 32'hFFFF_FFFF followed by a SNAP read returns hi = 0, not 1.
- Write and increment collide:
  - Running, write MTIME_LO = 5 in a tick cycle.
  - Next read gives 5, then 6; HI is unchanged.
- Prescaler (CPU6_TIMER_PRESCALER_EN defined):
  - CTRL = 32'h0000_0301 gives mtime +1 every 4 cycles.
  - With the macro undefined, the same write gives +1 per cycle and CTRL reads 32'h0000_0001.
- Reset pulse low mid-count with irq high:
  - mtime, CTRL and tmr_irq_r go to 0 immediately, without waiting for a clk edge.
